// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg: beam codes, FSM state encoding and beam lookup shared by the
// two-beam parking sensor generator, the counter and their benches.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package parking_pkg;

  // {a,b} beam codes: a is the outer beam, b the inner beam
  localparam logic [1:0] SNS_NONE = 2'b00;
  localparam logic [1:0] SNS_A    = 2'b10;
  localparam logic [1:0] SNS_AB   = 2'b11;
  localparam logic [1:0] SNS_B    = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Entry crosses outer then inner beam; exit is the mirror image
  function automatic logic [1:0] beam_of(input state_t st, input logic is_exit);
    logic [1:0] beam;
    beam = SNS_NONE;
    case (st)
      P1:      beam = is_exit ? SNS_B : SNS_A;
      P2:      beam = SNS_AB;
      P3:      beam = is_exit ? SNS_A : SNS_B;
      default: beam = SNS_NONE;
    endcase
    return beam;
  endfunction

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parking_phase_timer.sv
// ---------------------------------------------------------------------------
// parking_phase_timer: loadable down-counter; expired is high at zero.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module parking_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Loading N-1 keeps the current phase for exactly N cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/parking_sensor_gen.sv
// ---------------------------------------------------------------------------
// parking_sensor_gen: turns entry/exit requests into {a,b} beam waveforms and
// tracks the occupancy the parking counter should report.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module parking_sensor_gen #(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8,
  parameter int MAX_CARS    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_exit,
  output logic             req_ready,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             reject,
  output logic [CNT_W-1:0] occ
);

  import parking_pkg::*;

  localparam int TW = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [TW-1:0]    HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] OCC_MAX   = CNT_W'(MAX_CARS);

  state_t          state;
  state_t          next_state;
  logic            accept;
  logic            legal;
  logic            phase;
  logic            finish;
  logic            load;
  logic [TW-1:0]   load_val;
  logic            timer_expired;
  logic            dir_exit;
  logic            aborted;
  logic            rej_pend;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;
  assign legal     = req_exit ? (occ != '0) : (occ != OCC_MAX);
  assign phase     = (state == P1) || (state == P2) || (state == P3);
  assign finish    = (state == GAP) && timer_expired;

  parking_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = HOLD_LOAD;
    case (state)
      IDLE: begin
        if (accept && legal) begin
          next_state = P1;
          load       = 1'b1;
        end
      end
      P1: begin
        if (abort) begin
          next_state = GAP;
          load       = 1'b1;
          load_val   = GAP_LOAD;
        end else if (timer_expired) begin
          next_state = P2;
          load       = 1'b1;
        end
      end
      P2: begin
        if (abort) begin
          next_state = GAP;
          load       = 1'b1;
          load_val   = GAP_LOAD;
        end else if (timer_expired) begin
          next_state = P3;
          load       = 1'b1;
        end
      end
      P3: begin
        if (abort || timer_expired) begin
          next_state = GAP;
          load       = 1'b1;
          load_val   = GAP_LOAD;
        end
      end
      GAP: begin
        if (timer_expired) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Beams are registered from the current state, so they trail the FSM by one
  // edge; an abort blanks them on the same edge the FSM jumps to GAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_exit <= 1'b0;
      aborted  <= 1'b0;
      occ      <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      done     <= 1'b0;
      rej_pend <= 1'b0;
      reject   <= 1'b0;
    end else begin
      done     <= finish & ~aborted;
      rej_pend <= accept & ~legal;
      reject   <= rej_pend;
      if (accept && legal) begin
        dir_exit <= req_exit;
        aborted  <= 1'b0;
      end else if (phase && abort) begin
        aborted  <= 1'b1;
      end
      if (finish && !aborted) begin
        occ <= dir_exit ? (occ - CNT_W'(1)) : (occ + CNT_W'(1));
      end
      {a, b} <= (phase && abort) ? SNS_NONE : beam_of(state, dir_exit);
    end
  end

endmodule

`default_nettype wire
